// File: rtl/ili9341_pixel_streamer_pkg.sv
// streamer_pkg: shared state encoding, pixel type and widths for the ILI9341 pixel streamer
package streamer_pkg;
  localparam int ADDR_W = 17;
  localparam int IDX_W = 4;
  typedef logic [15:0] rgb565_t;
  typedef enum logic [2:0] {IDLE, CUR_REQ, CUR_WAIT, FETCH, LOOKUP, SEND, DRAIN} state_t;
endpackage

// File: rtl/ili9341_pixel_streamer_if.sv
// ili9341_pixel_streamer_if: pixel/cursor handshake between the streamer (master) and the ILI9341 driver (slave)
interface ili9341_pixel_streamer_if;
  import streamer_pkg::*;
  rgb565_t pix_data;
  logic pix_clk;
  logic reset_cursor;
  logic busy;
  modport master(output pix_data, pix_clk, reset_cursor, input busy);
  modport slave(input pix_data, pix_clk, reset_cursor, output busy);
endinterface

// File: rtl/ili9341_pixel_streamer_palette.sv
// streamer_palette: 16x16 RGB565 register file, synchronous write, combinational read (old value on same-cycle write)
module streamer_palette
  import streamer_pkg::*;
(
  input  logic             clk_16MHz,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  rgb565_t          wdata,
  input  logic [IDX_W-1:0] raddr,
  output rgb565_t          rdata
);
  rgb565_t mem [2**IDX_W];
  always_ff @(posedge clk_16MHz)
    if (reset) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/ili9341_pixel_streamer.sv
// ili9341_pixel_streamer: raster scan-out through a palette to the ILI9341 driver; STREAMER_PIXEL_DOUBLE_EN enables 2x2 pixel doubling
module ili9341_pixel_streamer
  import streamer_pkg::*;
#(
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input  logic                     clk_16MHz,
  input  logic                     reset,
  input  logic                     enable,
  output logic [ADDR_W-1:0]        fb_addr,
  input  logic [IDX_W-1:0]         fb_data,
  input  logic                     pal_we,
  input  logic [IDX_W-1:0]         pal_addr,
  input  rgb565_t                  pal_wdata,
  ili9341_pixel_streamer_if.master drv,
  output logic                     frame_done
);
  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  state_t state;
  logic [XW-1:0] x, nx;
  logic [YW-1:0] y, ny;
  logic x_last, y_last;
  logic [ADDR_W-1:0] next_addr;
  rgb565_t pal_rdata;
  streamer_palette u_pal (
    .clk_16MHz(clk_16MHz),
    .reset(reset),
    .we(pal_we),
    .waddr(pal_addr),
    .wdata(pal_wdata),
    .raddr(fb_data),
    .rdata(pal_rdata)
  );
  always_comb begin
    x_last = x == XW'(H_RES - 1);
    y_last = y == YW'(V_RES - 1);
    nx = x_last ? '0 : x + 1'b1;
    ny = x_last ? (y_last ? '0 : y + 1'b1) : y;
`ifdef STREAMER_PIXEL_DOUBLE_EN
    next_addr = ADDR_W'(32'(ny >> 1) * (H_RES / 2) + 32'(nx >> 1));
`else
    next_addr = ADDR_W'(32'(ny) * H_RES + 32'(nx));
`endif
  end
  // fb_addr is loaded with the coordinates the next FETCH will use; a frame always starts at (0,0)
  always_ff @(posedge clk_16MHz)
    if (reset) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      fb_addr <= '0;
      drv.pix_data <= '0;
      drv.pix_clk <= 1'b0;
      drv.reset_cursor <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (enable && !drv.busy) begin
          state <= CUR_REQ;
          drv.reset_cursor <= 1'b1;
        end
        CUR_REQ: if (drv.busy) begin
          state <= CUR_WAIT;
          drv.reset_cursor <= 1'b0;
        end
        CUR_WAIT: if (!drv.busy) begin
          state <= FETCH;
          fb_addr <= '0;
        end
        FETCH: state <= LOOKUP;
        LOOKUP: begin
          state <= SEND;
          drv.pix_data <= pal_rdata;
          drv.pix_clk <= 1'b1;
        end
        SEND: if (drv.busy) begin
          state <= DRAIN;
          drv.pix_clk <= 1'b0;
        end
        DRAIN: if (!drv.busy) begin
          x <= nx;
          y <= ny;
          fb_addr <= next_addr;
          if (x_last && y_last) begin
            frame_done <= 1'b1;
            state <= enable ? CUR_REQ : IDLE;
            drv.reset_cursor <= enable;
          end else state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
